// File: rtl/qx1_ctl_fsm.sv
// QX1 multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// request timeouts and a sticky FAULT state.
module qx1_ctl_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        imem_ack,
    input  logic [15:0] instr,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic        imem_rd,
    output logic        ir_write,
    output logic [3:0]  opcode,
    output logic [1:0]  alu_op,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_LW  = 4'h0;
    localparam logic [3:0] OP_SW  = 4'h1;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_NOP = 4'hD;
    localparam logic [3:0] OP_ILL = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_ir_op;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [1:0]  r_fault_code;
    logic [1:0]  w_fault_code_next;
    logic        w_unused_instr;

    // Only the opcode field is consumed here; the jump target goes to the PC datapath.
    assign w_unused_instr = ^instr[11:0];

    assign opcode     = r_ir_op;
    assign fault_code = r_fault_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ir_op      <= 4'h0;
            r_cnt        <= 8'h00;
            r_fault_code <= 2'b00;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_fault_code <= w_fault_code_next;
            if (ir_write) begin
                r_ir_op <= instr[15:12];
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_fault_code_next = r_fault_code;
        imem_rd    = 1'b0;
        ir_write   = 1'b0;
        alu_op     = 2'b00;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_rd = 1'b1;
                // An ack on the final allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_write     = 1'b1;
                    pc_write     = 1'b1;
                    w_state_next = S_DECODE;
                    w_cnt_next   = 8'h00;
                end else if (r_cnt == TO_LAST) begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = 2'b10;
                    w_cnt_next        = 8'h00;
                end else begin
                    w_cnt_next = r_cnt + 8'h01;
                end
            end
            S_DECODE: begin
                case (r_ir_op)
                    OP_JMP: begin
                        pc_write     = 1'b1;
                        pc_src       = 2'b10;
                        w_state_next = S_FETCH;
                    end
                    OP_NOP:  w_state_next = S_FETCH;
                    OP_HLT:  w_state_next = S_HALT;
                    OP_ILL: begin
                        w_state_next      = S_FAULT;
                        w_fault_code_next = 2'b01;
                    end
                    default: w_state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (r_ir_op == OP_LW || r_ir_op == OP_SW) begin
                    alu_op       = 2'b10;
                    w_state_next = S_MEM;
                end else if (r_ir_op == OP_BEQ || r_ir_op == OP_BNE) begin
                    alu_op       = 2'b01;
                    pc_src       = 2'b01;
                    pc_write     = (r_ir_op == OP_BEQ) ? alu_zero : !alu_zero;
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                if (r_ir_op == OP_SW) dmem_wr = 1'b1;
                else                  dmem_rd = 1'b1;
                if (dmem_ack) begin
                    w_state_next = (r_ir_op == OP_SW) ? S_FETCH : S_WB;
                    w_cnt_next   = 8'h00;
                end else if (r_cnt == TO_LAST) begin
                    w_state_next      = S_FAULT;
                    w_fault_code_next = 2'b11;
                    w_cnt_next        = 8'h00;
                end else begin
                    w_cnt_next = r_cnt + 8'h01;
                end
            end
            S_WB: begin
                reg_write    = 1'b1;
                mem_to_reg   = (r_ir_op == OP_LW);
                w_state_next = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (!run) w_state_next = S_IDLE;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

endmodule
